// File: rtl/alu_arb_pkg.sv
// -----------------------------------------------------------------------------
// alu_arb_pkg
//   Shared constants and types for the two-requester ALU arbiter.
//   NUM_REQ    number of requesters sharing the ALU
//   DEF_WIDTH  default operand/result width
//   DEF_SEL_W  default ALU opcode width
//   state_t    arbiter FSM states (IDLE -> ISSUE -> RESP -> IDLE)
// -----------------------------------------------------------------------------
package alu_arb_pkg;

  localparam int NUM_REQ   = 2;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_SEL_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

endpackage

// File: rtl/rr_pick2.sv
// -----------------------------------------------------------------------------
// rr_pick2
//   Combinational two-way round-robin pick.
//   valid[1:0]  in   requests
//   ptr         in   requester preferred when both are valid
//   gnt[1:0]    out  one-hot grant, zero when no request
//   idx         out  index of the granted requester (0 when none)
// -----------------------------------------------------------------------------
module rr_pick2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] gnt,
  output logic       idx
);

  always_comb begin
    // Requester 1 wins when it is alone, or when both ask and it holds the pointer.
    idx = valid[1] & (~valid[0] | ptr);
    gnt = 2'b00;
    if (valid != 2'b00) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/alu_rr_arbiter.sv
// -----------------------------------------------------------------------------
// alu_rr_arbiter
//   Shares one external combinational ALU between two requesters. One operation
//   is in flight at a time: accept (IDLE), drive the ALU for one cycle (ISSUE),
//   then hold the registered result until the winner takes it (RESP).
//
//   clk, rst               single clock; synchronous active-high reset
//   req_valid/req_ready    per-requester operation handshake (ready one-hot or 0)
//   req_a/req_b/req_sel    packed operands, requester i at [i*W +: W]
//   resp_valid/resp_ready  per-requester result handshake (valid one-hot or 0)
//   resp_data              result for the requester flagged in resp_valid
//   alu_a/alu_b/alu_sel    registered operands to the ALU
//   alu_en                 ALU enable, high only in ISSUE
//   alu_salida             ALU result
//
//   Optional: define ALU_ARB_STATS_EN to add grant_cnt0/grant_cnt1, 16-bit
//   wrapping counts of accepted operations per requester.
// -----------------------------------------------------------------------------
module alu_rr_arbiter
  import alu_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEL_W = DEF_SEL_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ*SEL_W-1:0] req_sel,
  output logic [NUM_REQ-1:0]       resp_valid,
  input  logic [NUM_REQ-1:0]       resp_ready,
  output logic [WIDTH-1:0]         resp_data,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  output logic [SEL_W-1:0]         alu_sel,
  output logic                     alu_en,
  input  logic [WIDTH-1:0]         alu_salida
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0]              grant_cnt0,
  output logic [15:0]              grant_cnt1
`endif
);

  state_t              state_q, state_d;
  logic                ptr_q;
  logic                win_q;
  logic [NUM_REQ-1:0]  pick_gnt;
  logic                pick_idx;
  logic                accept;
  logic                done;

  rr_pick2 u_pick (
    .valid (req_valid),
    .ptr   (ptr_q),
    .gnt   (pick_gnt),
    .idx   (pick_idx)
  );

  assign accept = (state_q == IDLE) && (req_valid != '0);
  assign done   = (state_q == RESP) && resp_ready[win_q];

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned, which would infer a latch.
    state_d    = state_q;
    req_ready  = '0;
    resp_valid = '0;
    alu_en     = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = pick_gnt;
        if (accept) state_d = ISSUE;
      end
      ISSUE: begin
        alu_en  = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        resp_valid[win_q] = 1'b1;
        if (done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous; all state including the operand registers is
    // cleared so an aborted operation leaves nothing visible.
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= 1'b0;
      win_q     <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      resp_data <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        win_q   <= pick_idx;
        alu_a   <= pick_idx ? req_a[WIDTH +: WIDTH]   : req_a[0 +: WIDTH];
        alu_b   <= pick_idx ? req_b[WIDTH +: WIDTH]   : req_b[0 +: WIDTH];
        alu_sel <= pick_idx ? req_sel[SEL_W +: SEL_W] : req_sel[0 +: SEL_W];
      end
      if (state_q == ISSUE) resp_data <= alu_salida;
      // The requester just served loses priority on the next tie.
      if (done) ptr_q <= ~win_q;
    end
  end

`ifdef ALU_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else if (accept) begin
      if (pick_idx) grant_cnt1 <= grant_cnt1 + 16'd1;
      else          grant_cnt0 <= grant_cnt0 + 16'd1;
    end
  end
`endif

endmodule
